// File: rtl/dat_mem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   addr_t / data_t : default-width address and data words
//   arb_state_t     : arbiter FSM states
//   LCW             : lock counter width for the default MAX_LOCK
package dat_mem_arb_pkg;

  localparam int unsigned AW_DEF       = 8;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned MAX_LOCK_DEF = 4;
  localparam int unsigned LCW          = $clog2(MAX_LOCK_DEF + 1);

  typedef logic [AW_DEF-1:0] addr_t;
  typedef logic [DW_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dat_mem_arb_rr2.sv
// Combinational two-way round-robin pick.
//   req  in  2  request vector
//   last in  1  index of the previous winner
//   gnt  out 2  one-hot (or zero) grant; on a tie the port other than last wins
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/dat_mem_arb.sv
// Two-requester arbiter for the single-port data memory.
// Port 0 = core load/store unit, port 1 = loader/DMA engine.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*      per-port request, write enable, address, write data
//   lock*                      hold the grant for the following cycle
//   gnt*                       combinational grant (transfer happens this cycle)
//   rvalid*/rdata*             registered read response, one cycle after a granted read
//   mem_addr/mem_wr_en/mem_dat_in/mem_dat_out   memory interface
module dat_mem_arb
  import dat_mem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_t    state, state_n;
  logic [CW-1:0] lock_cnt, cnt_n;
  logic          last;
  logic [1:0]    req, lock, rr_gnt, gnt_c;
  logic          own, peer;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};

  arb_rr2 u_rr (
    .req  (req),
    .last (last),
    .gnt  (rr_gnt)
  );

  // State register, lock counter, round-robin pointer and read responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      lock_cnt <= '0;
      last     <= 1'b1;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_n;
      lock_cnt <= cnt_n;
      if (gnt_c[0])      last <= 1'b0;
      else if (gnt_c[1]) last <= 1'b1;
      rvalid0 <= gnt_c[0] & ~we0;
      rvalid1 <= gnt_c[1] & ~we1;
      if (gnt_c[0] && !we0) rdata0 <= mem_dat_out;
      if (gnt_c[1] && !we1) rdata1 <= mem_dat_out;
    end
  end

  // Next state and grant. Both lock states share one path: own = locked port.
  always_comb begin
    state_n = state;
    cnt_n   = lock_cnt;
    gnt_c   = '0;
    own     = (state == LOCK1);
    peer    = ~own;
    unique case (state)
      ARB: begin
        gnt_c = rr_gnt;
        cnt_n = '0;
        if (rr_gnt[0] && lock0) begin
          state_n = LOCK0;
          cnt_n   = CNT_ONE;
        end else if (rr_gnt[1] && lock1) begin
          state_n = LOCK1;
          cnt_n   = CNT_ONE;
        end
      end
      LOCK0, LOCK1: begin
        if (!req[own]) begin
          gnt_c[peer] = req[peer];
          state_n     = ARB;
          cnt_n       = '0;
        end else if (req[peer] && lock_cnt == CNT_MAX) begin
          // Forced hand-over: the waiting peer gets this slot.
          gnt_c[peer] = 1'b1;
          state_n     = lock[peer] ? (peer ? LOCK1 : LOCK0) : ARB;
          cnt_n       = lock[peer] ? CNT_ONE : '0;
        end else begin
          gnt_c[own] = 1'b1;
          if (lock[own]) begin
            cnt_n = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + CNT_ONE;
          end else begin
            state_n = ARB;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ARB;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs: grants are suppressed while reset is asserted so no write commits.
  always_comb begin
    gnt0       = gnt_c[0] & rst_n;
    gnt1       = gnt_c[1] & rst_n;
    mem_addr   = gnt1 ? addr1  : addr0;
    mem_dat_in = gnt1 ? wdata1 : wdata0;
    mem_wr_en  = (gnt0 & we0) | (gnt1 & we1);
  end

endmodule

// File: tb/tb_dat_mem_arb.sv
module tb_dat_mem_arb;
  import dat_mem_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_wr_en;
  logic [7:0] rdata0, rdata1, mem_addr, mem_dat_in, mem_dat_out;

  logic [7:0] mem [256];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

  dat_mem_arb #(.AW(8), .DW(8), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected read data whenever a response appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid0) begin
        if (q0.size() == 0) check("rvalid0_unexpected", 32'(rvalid0), 32'd0);
        else check("rdata0", 32'(rdata0), 32'(q0.pop_front()));
      end
      if (rvalid1) begin
        if (q1.size() == 0) check("rvalid1_unexpected", 32'(rvalid1), 32'd0);
        else check("rdata1", 32'(rdata1), 32'(q1.pop_front()));
      end
    end
  end

  // One cycle of stimulus; grant checked before the edge, expected reads queued.
  task automatic cyc(input string name,
                     input logic r0, input logic w0, input logic l0,
                     input logic [7:0] a0, input logic [7:0] d0,
                     input logic r1, input logic w1, input logic l1,
                     input logic [7:0] a1, input logic [7:0] d1,
                     input logic [1:0] exp_gnt, input logic [7:0] exp_rd);
    @(negedge clk);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
    check(name, {30'd0, gnt1, gnt0}, {30'd0, exp_gnt});
    if (exp_gnt[0] && !w0) q0.push_back(exp_rd);
    if (exp_gnt[1] && !w1) q1.push_back(exp_rd);
  endtask

  task automatic idle(input string name);
    cyc(name, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, with a request held to show grants are forced off
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'h99;
    @(negedge clk); #1;
    check("rst_gnt0", 32'(gnt0), 0);
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    check("rst_rdata", {16'd0, rdata1, rdata0}, 0);
    req0 = 0; we0 = 0;
    @(negedge clk); rst_n = 1'b1;

    // Preload through the ports; idle bus drives addr0
    cyc("pre_w10", 1, 1, 0, 8'h10, 8'h11, 0, 0, 0, 8'h00, 8'h00, 2'b01, 8'h00);
    cyc("pre_w20", 1, 1, 0, 8'h20, 8'h5C, 0, 0, 0, 8'h00, 8'h00, 2'b01, 8'h00);
    cyc("pre_w00", 0, 0, 0, 8'h42, 8'h00, 1, 1, 0, 8'h00, 8'h00, 2'b10, 8'h00);
    cyc("idle_nogrant", 0, 0, 0, 8'h42, 8'h00, 0, 0, 0, 8'h77, 8'h00, 2'b00, 8'h00);
    check("idle_addr", 32'(mem_addr), 32'h42);
    check("idle_wr_en", 32'(mem_wr_en), 0);

    // 1: reset asserted mid-write
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hAA; req1 = 0;
    #1 rst_n = 1'b0;
    #1;
    check("t1_gnt0", 32'(gnt0), 0);
    check("t1_wr_en", 32'(mem_wr_en), 0);
    @(negedge clk);
    check("t1_mem10", 32'(mem[8'h10]), 32'h11);
    check("t1_rvalid0", 32'(rvalid0), 0);
    req0 = 0; we0 = 0;
    rst_n = 1'b1;

    // 2: single read on port 1
    cyc("t2_gnt", 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b10, 8'h5C);
    idle("t2_idle");
    check("t2_rvalid1", 32'(rvalid1), 1);
    check("t2_rvalid0", 32'(rvalid0), 0);

    // 3: contention right after reset alternates 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc("t3_gnt", 1, 1, 0, 8'h30, 8'hA0 + 8'(i), 1, 1, 0, 8'h31, 8'hB0 + 8'(i),
          (i % 2 == 0) ? 2'b01 : 2'b10, 8'h00);
    end
    idle("t3_idle");
    check("t3_mem30", 32'(mem[8'h30]), 32'hA2);
    check("t3_mem31", 32'(mem[8'h31]), 32'hB3);

    // 4: lock fairness, four locked grants then the peer is forced in
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc("t4_gnt", 1, 1, 1, 8'h50, 8'hC0 + 8'(i), 1, 1, 0, 8'h51, 8'h5A,
          (i == 4) ? 2'b10 : 2'b01, 8'h00);
    end
    idle("t4_idle");
    check("t4_state_lock0", 32'(dut.state), 32'(LOCK0));
    check("t4_mem51", 32'(mem[8'h51]), 32'h5A);

    // 5: read-after-write and address wrap
    cyc("t5_wFF", 1, 1, 0, 8'hFF, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 2'b01, 8'h00);
    cyc("t5_rFF", 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h00, 2'b10, 8'h3C);
    cyc("t5_w00", 1, 1, 0, 8'h00, 8'h77, 0, 0, 0, 8'h00, 8'h00, 2'b01, 8'h00);
    cyc("t5_r00", 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b01, 8'h77);
    cyc("t5_rFF2", 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h00, 2'b10, 8'h3C);
    idle("t5_idle");
    check("t5_memFF", 32'(mem[8'hFF]), 32'h3C);
    check("t5_mem00", 32'(mem[8'h00]), 32'h77);

    // 6: lock release, port 1 drops its request while port 0 waits
    cyc("t6_lock1", 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h20, 8'h00, 2'b10, 8'h5C);
    cyc("t6_gnt0", 1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b01, 8'h5C);
    check("t6_state_lock1", 32'(dut.state), 32'(LOCK1));
    check("t6_cnt_pre", 32'(dut.lock_cnt), 1);
    idle("t6_idle");
    check("t6_state_arb", 32'(dut.state), 32'(ARB));
    check("t6_cnt", 32'(dut.lock_cnt), 0);

    // Drain: every queued read must have been answered
    for (int i = 0; i < 3; i++) idle("drain");
    check("q0_empty", 32'(q0.size()), 0);
    check("q1_empty", 32'(q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
